// File: rtl/decoder_latent_dense.sv
// Dense layer expanding the 50-element latent vector to 100 neurons (Q10.10 data, Q2.4 weights).
// Optional ReLU activation after saturation is enabled by defining DECODER_RELU_EN.
module decoder_latent_dense #(
    parameter int IN_COUNT              = 50,
    parameter int OUT_COUNT             = 100,
    parameter int INTEGER_WIDTH         = 10,
    parameter int FRACTION_WIDTH        = 10,
    parameter int WEIGHT_BIT_WIDTH      = 6,
    parameter int WEIGHT_FRACTION_WIDTH = 4,
    parameter int READ_LATENCY          = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic [6:0]                                latent_address,
    output logic                                      latent_enable,
    input  logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]   latent_data,
    output logic [12:0]                               weight_address,
    input  logic [WEIGHT_BIT_WIDTH-1:0]               weight_data,
    output logic [6:0]                                bias_address,
    input  logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]   bias_data,
    input  logic [6:0]                                dec_output_address,
    input  logic                                      dec_output_enable,
    output logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]   dec_output_data,
    output logic                                      busy,
    output logic                                      done
);

    localparam int DATA_WIDTH = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_BIT_WIDTH;
    localparam int PHASE_LEN  = IN_COUNT + READ_LATENCY;
    localparam int CNT_W      = $clog2(PHASE_LEN + 1);
    localparam int BUF_AW     = $clog2(IN_COUNT);
    localparam int MEM_AW     = $clog2(OUT_COUNT);

    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (DATA_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (DATA_WIDTH - 1));
    localparam logic [DATA_WIDTH-1:0] SAT_MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [6:0]               j_q, j_d;
    logic signed [31:0]       acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic [6:0]               latent_address_q, latent_address_d;
    logic                     latent_enable_q, latent_enable_d;
    logic [12:0]              weight_address_q, weight_address_d;
    logic [6:0]               bias_address_q, bias_address_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    dec_output_data_q, dec_output_data_d;

    logic [DATA_WIDTH-1:0]    buf_q [IN_COUNT];
    logic [DATA_WIDTH-1:0]    mem_q [OUT_COUNT];
    logic                     buf_we_s;
    logic [BUF_AW-1:0]        buf_idx_s;
    logic                     mem_we_s;

    // Product of one latent element and one weight, rescaled to Q10.10 by flooring shift.
    function automatic logic signed [31:0] mac_term(input logic signed [DATA_WIDTH-1:0] x,
                                                    input logic signed [WEIGHT_BIT_WIDTH-1:0] w);
        logic signed [PROD_WIDTH-1:0] p;
        p = PROD_WIDTH'(x) * PROD_WIDTH'(w);
        p = p >>> WEIGHT_FRACTION_WIDTH;
        return {{(32-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [31:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX_V;
        end else if (v < SAT_MIN) begin
            return SAT_MIN_V;
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] v);
`ifdef DECODER_RELU_EN
        if (v[DATA_WIDTH-1]) begin
            return '0;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // Buffer slot that the returned read data belongs to, READ_LATENCY cycles behind the counter.
    assign buf_idx_s = BUF_AW'(cnt_q - CNT_W'(READ_LATENCY));

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        j_d               = j_q;
        acc_d             = acc_q;
        result_d          = result_q;
        latent_address_d  = latent_address_q;
        latent_enable_d   = 1'b0;
        weight_address_d  = weight_address_q;
        bias_address_d    = bias_address_q;
        busy_d            = busy_q;
        done_d            = done_q;
        buf_we_s          = 1'b0;
        mem_we_s          = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d          = S_LOAD;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    cnt_d            = '0;
                    latent_address_d = 7'd0;
                    latent_enable_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (int'(cnt_q) >= READ_LATENCY) begin
                    buf_we_s = 1'b1;
                end else begin
                    buf_we_s = 1'b0;
                end
                if (int'(cnt_q) + 1 < IN_COUNT) begin
                    latent_enable_d  = 1'b1;
                    latent_address_d = 7'(cnt_q) + 7'd1;
                end else begin
                    latent_enable_d  = 1'b0;
                end
                if (int'(cnt_q) == PHASE_LEN - 1) begin
                    state_d          = S_MAC;
                    cnt_d            = '0;
                    j_d              = 7'd0;
                    acc_d            = 32'sd0;
                    weight_address_d = 13'd0;
                    bias_address_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MAC: begin
                if (int'(cnt_q) >= READ_LATENCY) begin
                    acc_d = acc_q + mac_term(buf_q[buf_idx_s], weight_data);
                end else begin
                    acc_d = acc_q;
                end
                if (int'(cnt_q) + 1 < IN_COUNT) begin
                    weight_address_d = weight_address_q + 13'd1;
                end else begin
                    weight_address_d = weight_address_q;
                end
                if (int'(cnt_q) == PHASE_LEN - 1) begin
                    state_d = S_BIAS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BIAS: begin
                result_d = activate(saturate(acc_q +
                           $signed({{(32-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data})));
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_we_s = 1'b1;
                acc_d    = 32'sd0;
                if (j_q == 7'(OUT_COUNT - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Weight address sits at j*IN_COUNT+IN_COUNT-1, so +1 is the next row start.
                    state_d          = S_MAC;
                    j_d              = j_q + 7'd1;
                    cnt_d            = '0;
                    bias_address_d   = j_q + 7'd1;
                    weight_address_d = weight_address_q + 13'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Downstream read port: registered lookup, hold when not enabled.
    always_comb begin
        dec_output_data_d = dec_output_data_q;
        if (dec_output_enable) begin
            if (dec_output_address < 7'(OUT_COUNT)) begin
                dec_output_data_d = mem_q[MEM_AW'(dec_output_address)];
            end else begin
                dec_output_data_d = '0;
            end
        end else begin
            dec_output_data_d = dec_output_data_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            j_q               <= 7'd0;
            acc_q             <= 32'sd0;
            result_q          <= '0;
            latent_address_q  <= 7'd0;
            latent_enable_q   <= 1'b0;
            weight_address_q  <= 13'd0;
            bias_address_q    <= 7'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            dec_output_data_q <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            j_q               <= j_d;
            acc_q             <= acc_d;
            result_q          <= result_d;
            latent_address_q  <= latent_address_d;
            latent_enable_q   <= latent_enable_d;
            weight_address_q  <= weight_address_d;
            bias_address_q    <= bias_address_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            dec_output_data_q <= dec_output_data_d;
        end
    end

    // Latent buffer and result memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (buf_we_s && !reset) begin
            buf_q[buf_idx_s] <= latent_data;
        end
        if (mem_we_s && !reset) begin
            mem_q[MEM_AW'(j_q)] <= result_q;
        end
    end

    assign latent_address  = latent_address_q;
    assign latent_enable   = latent_enable_q;
    assign weight_address  = weight_address_q;
    assign bias_address    = bias_address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dec_output_data = dec_output_data_q;

endmodule

// File: tb/tb_decoder_latent_dense.sv
// Directed bench for decoder_latent_dense: ROM/encoder port models with two-cycle read latency,
// latency checks on every pass and a table of expected result-memory reads.
module tb_decoder_latent_dense;

    localparam int LAT_N = 50;
    localparam int OUT_N = 100;
    localparam int W_N   = LAT_N * OUT_N;
    localparam int PASS_CYCLES = 5452;

`ifdef DECODER_RELU_EN
    localparam logic [19:0] NEG_EXP = 20'h00000;
`else
    localparam logic [19:0] NEG_EXP = 20'hF3800;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  latent_address;
    logic        latent_enable;
    logic [19:0] latent_data;
    logic [12:0] weight_address;
    logic [5:0]  weight_data;
    logic [6:0]  bias_address;
    logic [19:0] bias_data;
    logic [6:0]  dec_output_address;
    logic        dec_output_enable;
    logic [19:0] dec_output_data;
    logic        busy;
    logic        done;

    logic [19:0] lat_mem [LAT_N];
    logic [5:0]  w_rom   [W_N];
    logic [19:0] b_rom   [OUT_N];
    logic [19:0] lat_s1;
    logic [5:0]  w_s1;
    logic [19:0] b_s1;

    int total;
    int bad;

    typedef struct {
        int          pass_id;
        logic [6:0]  addr;
        logic [19:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [19];

    decoder_latent_dense dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .latent_address     (latent_address),
        .latent_enable      (latent_enable),
        .latent_data        (latent_data),
        .weight_address     (weight_address),
        .weight_data        (weight_data),
        .bias_address       (bias_address),
        .bias_data          (bias_data),
        .dec_output_address (dec_output_address),
        .dec_output_enable  (dec_output_enable),
        .dec_output_data    (dec_output_data),
        .busy               (busy),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage read pipelines standing in for the encoder port and the ROMs.
    always @(posedge clk) begin
        if (latent_enable && latent_address < 7'd50) lat_s1 <= lat_mem[latent_address];
        latent_data <= lat_s1;
        w_s1        <= (weight_address < 13'd5000) ? w_rom[weight_address] : 6'd0;
        weight_data <= w_s1;
        b_s1        <= (bias_address < 7'd100) ? b_rom[bias_address] : 20'd0;
        bias_data   <= b_s1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < LAT_N; i++) begin
            case (mode)
                2:       lat_mem[i] = 20'h7FFFF;
                4:       lat_mem[i] = 20'((i + 1) << 10);
                default: lat_mem[i] = 20'h00400;
            endcase
        end
        for (int j = 0; j < OUT_N; j++) begin
            b_rom[j] = (mode == 3) ? 20'(j << 10) : 20'd0;
            for (int i = 0; i < LAT_N; i++) begin
                case (mode)
                    0:       w_rom[j*LAT_N + i] = 6'b010000;
                    1:       w_rom[j*LAT_N + i] = 6'b110000;
                    2:       w_rom[j*LAT_N + i] = 6'b011111;
                    4:       w_rom[j*LAT_N + i] = (i == (j % LAT_N)) ? 6'b010000 : 6'd0;
                    default: w_rom[j*LAT_N + i] = 6'd0;
                endcase
            end
        end
    endtask

    // Pulses start; optional second start at extra_at and reset at reset_at (cycles after start edge).
    task automatic run_pass(input int extra_at, input int reset_at, output int done_cyc);
        done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        for (int n = 1; n <= 6000; n++) begin
            start = (n == extra_at);
            reset = (n == reset_at);
            @(negedge clk);
            if (n == reset_at) begin
                reset = 1'b0;
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_latent_en", {31'd0, latent_enable}, 32'd0);
                done_cyc = n;
                break;
            end
            if (done) begin
                done_cyc = n;
                break;
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic read_chk(input logic [6:0] a, input logic [19:0] exp);
        @(negedge clk);
        dec_output_address = a;
        dec_output_enable  = 1'b1;
        @(negedge clk);
        dec_output_enable  = 1'b0;
        check($sformatf("read[%0d]", a), {12'd0, dec_output_data}, {12'd0, exp});
    endtask

    task automatic check_table(input int pass_id);
        for (int k = 0; k < 19; k++) begin
            if (tbl[k].pass_id == pass_id) read_chk(tbl[k].addr, tbl[k].exp);
        end
    endtask

    task automatic full_pass(input int extra_at, input string name);
        int dc;
        run_pass(extra_at, 0, dc);
        check({name, "_latency"}, 32'(dc), 32'(PASS_CYCLES));
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dc;
        total = 0;
        bad   = 0;
        tbl[0]  = '{0, 7'd0,   20'h0C800};
        tbl[1]  = '{0, 7'd50,  20'h0C800};
        tbl[2]  = '{0, 7'd99,  20'h0C800};
        tbl[3]  = '{1, 7'd0,   NEG_EXP};
        tbl[4]  = '{1, 7'd99,  NEG_EXP};
        tbl[5]  = '{2, 7'd0,   20'h7FFFF};
        tbl[6]  = '{2, 7'd63,  20'h7FFFF};
        tbl[7]  = '{3, 7'd0,   20'h00000};
        tbl[8]  = '{3, 7'd1,   20'h00400};
        tbl[9]  = '{3, 7'd42,  20'h0A800};
        tbl[10] = '{3, 7'd99,  20'h18C00};
        tbl[11] = '{3, 7'd120, 20'h00000};
        tbl[12] = '{3, 7'd127, 20'h00000};
        tbl[13] = '{4, 7'd0,   20'h00400};
        tbl[14] = '{4, 7'd12,  20'h03400};
        tbl[15] = '{4, 7'd49,  20'h0C800};
        tbl[16] = '{4, 7'd50,  20'h00400};
        tbl[17] = '{4, 7'd73,  20'h06000};
        tbl[18] = '{4, 7'd99,  20'h0C800};

        reset = 1'b1;
        start = 1'b0;
        dec_output_address = 7'd0;
        dec_output_enable  = 1'b0;
        lat_s1 = 20'd0;
        w_s1   = 6'd0;
        b_s1   = 20'd0;
        fill(0);
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_latent_en", {31'd0, latent_enable}, 32'd0);
        check("reset_latent_addr", {25'd0, latent_address}, 32'd0);
        check("reset_weight_addr", {19'd0, weight_address}, 32'd0);
        check("reset_bias_addr", {25'd0, bias_address}, 32'd0);
        check("reset_dec_data", {12'd0, dec_output_data}, 32'd0);
        reset = 1'b0;

        full_pass(0, "passA");
        repeat (4) @(negedge clk);
        check("done_held", {31'd0, done}, 32'd1);
        check_table(0);

        fill(1);
        full_pass(0, "passB");
        check_table(1);

        fill(2);
        full_pass(0, "passC");
        check_table(2);

        fill(3);
        full_pass(0, "passD");
        check_table(3);
        read_chk(7'd99, 20'h18C00);
        repeat (2) @(negedge clk);
        check("read_hold", {12'd0, dec_output_data}, 32'h18C00);

        fill(4);
        run_pass(0, 1000, dc);
        check("reset_abort_seen", 32'(dc), 32'd1000);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        full_pass(0, "passE");
        check_table(4);

        full_pass(10, "passE_restart");
        check_table(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_latent_dense.md
# decoder_latent_dense

First stage of the decoder half of the autoencoder: a fully-connected layer that expands the encoder's 50-element latent vector back to 100 neurons. It sits directly behind the encoder. It reads the latent vector through the encoder's output read port (address/enable/data), then streams 6-bit weights and 20-bit biases from ROM BRAMs. Results are stored internally and exposed through the same style of read port, so the next decoder layer can fetch them.

## Interface
Parameters:
- IN_COUNT, 50, latent elements consumed
- OUT_COUNT, 100, neurons produced
- INTEGER_WIDTH, 10, integer bits of Q-format data
- FRACTION_WIDTH, 10, fraction bits of Q-format data
- WEIGHT_BIT_WIDTH, 6, signed weight width
- WEIGHT_FRACTION_WIDTH, 4, fraction bits of weight (weight 6'b010000 = +1.0)
- READ_LATENCY, 2, cycles from address driven to data valid on latent, weight and bias inputs

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a pass when not busy
- latent_address  out  7  element index to encoder output port
- latent_enable  out  1  read enable to encoder output port
- latent_data  in  20  signed Q10.10 latent element
- weight_address  out  13  weight ROM address = j*IN_COUNT + i
- weight_data  in  6  signed weight
- bias_address  out  7  bias ROM address = j
- bias_data  in  20  signed Q10.10 bias
- dec_output_address  in  7  result index for downstream reader
- dec_output_enable  in  1  downstream read enable
- dec_output_data  out  20  signed Q10.10 result
- busy  out  1  high from accepted start until done rises
- done  out  1  high after pass completes; held until next accepted start or reset

## Operation
- States: IDLE, LOAD, MAC, BIAS, WRITE, DONE.
- IDLE/DONE + start: busy=1, done=0, go to LOAD. Start while busy is ignored.
- LOAD: latent_enable=1 and latent_address=0..IN_COUNT-1, one address per cycle. Data is captured into an internal IN_COUNT×20 buffer READ_LATENCY cycles later. After the last capture, latent_enable=0 and the FSM goes to MAC with j=0.
- MAC (per neuron j):
  - One weight address per cycle for i=0..IN_COUNT-1. bias_address=j is driven on MAC entry.
  - Each returned weight is multiplied by buffer[i] (signed 20×6 → 26 bits), arithmetic-shifted right by WEIGHT_FRACTION_WIDTH (truncation toward −∞), and summed in a 32-bit signed accumulator.
  - After READ_LATENCY drain cycles the FSM goes to BIAS.
- BIAS: add sign-extended bias_data, then saturate to [0x80000, 0x7FFFF]; apply activation (see Configuration).
- WRITE: store into result memory[j], clear accumulator. If j<OUT_COUNT-1, increment j and return to MAC; otherwise go to DONE.
- DONE: done=1, busy=0.
- Read port: dec_output_enable=1 registers memory[dec_output_address] onto dec_output_data one cycle later; otherwise dec_output_data holds. Reads are legal at any time; reads while busy may return stale values. A read and a write to the same index in the same cycle returns the old value.
- Out-of-range dec_output_address (≥OUT_COUNT) returns 0.

## Timing
- Reset values: latent_address=0, latent_enable=0, weight_address=0, bias_address=0, dec_output_data=0, busy=0, done=0, state IDLE, accumulator 0. Result memory contents are retained.
- Reset mid-pass aborts immediately to IDLE. A later start runs a full clean pass.
- Per neuron: IN_COUNT + READ_LATENCY + 2 cycles.
- LOAD: IN_COUNT + READ_LATENCY cycles.
- Start-to-done latency: (IN_COUNT+READ_LATENCY) + OUT_COUNT×(IN_COUNT+READ_LATENCY+2) cycles. With defaults: 52 + 5400 = 5452 cycles after the start edge.
- One MAC per cycle, no stalls; the input sources must honour READ_LATENCY exactly.

## Configuration
- DECODER_RELU_EN defined: after saturation, negative results are forced to 0 (ReLU).
- DECODER_RELU_EN undefined: linear output; the saturated value is stored unchanged.

## Test plan
- Latent all 0x00400 (1.0), weights all 6'b010000, biases 0 → every output 0x0C800 (50.0); done rises 5452 cycles after start, busy low the same cycle.
- Latent 1.0, weights 6'b110000 (−1.0), biases 0 → outputs 0 with DECODER_RELU_EN; 0xF3800 without.
- Latent all 0x7FFFF, weights 6'b011111 → every output saturates to 0x7FFFF.
- Weights 0, bias[j]=j<<10 → output[j]=j<<10; read address 99 → 0x18C00 one cycle after enable; address 120 → 0.
- Reset asserted at cycle 1000 of a pass → next cycle busy=0, done=0, latent_enable=0; a new start completes with correct results after 5452 cycles.
- Second start pulse at cycle 10 of a pass → ignored; done still at 5452 and the result set is unchanged.
